// File: rtl/periodic_pkg.sv
// Shared definitions for the periodic_gen timer/PWM channel.
package periodic_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_PRE_WIDTH = 4;

  typedef enum logic [1:0] {
    MODE_PULSE   = 2'b00,
    MODE_SQUARE  = 2'b01,
    MODE_PWM     = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

endpackage

// File: rtl/clk_prescaler.sv
// Programmable prescaler: asserts step on every (div+1)-th enabled cycle.
module clk_prescaler #(
  parameter int unsigned PRE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [PRE_WIDTH-1:0] div,
  output logic                 step
);

  logic [PRE_WIDTH-1:0] cnt_q, cnt_d;
  logic                 hit;

  always_comb begin
    hit   = (cnt_q == div);
    step  = en && hit;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = hit ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/periodic_gen.sv
// Reloadable up-counter behind a prescaler, with shadowed configuration and
// pulse / square / PWM / one-shot waveform output. All outputs registered.
module periodic_gen
  import periodic_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned PRE_WIDTH = DEF_PRE_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic                 start,
  input  logic [WIDTH-1:0]     ld_num,
  input  logic [WIDTH-1:0]     cmp,
  input  logic [PRE_WIDTH-1:0] presc,
  input  logic [1:0]           mode,
  output logic [WIDTH-1:0]     cnt,
  output logic                 tick,
  output logic                 wave,
  output logic                 busy
);

  logic [WIDTH-1:0]     ld_sh_q, ld_sh_d;
  logic [WIDTH-1:0]     cmp_sh_q, cmp_sh_d;
  logic [PRE_WIDTH-1:0] presc_sh_q, presc_sh_d;
  mode_e                mode_sh_q, mode_sh_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic                 tick_q, tick_d;
  logic                 wave_q, wave_d;
  logic                 busy_q, busy_d;

  logic start_ok, run, ps_en, ps_clr, step, wrap;

  clk_prescaler #(
    .PRE_WIDTH(PRE_WIDTH)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .en  (ps_en),
    .clr (ps_clr),
    .div (presc_sh_q),
    .step(step)
  );

  always_comb begin
    start_ok = (mode_sh_q == MODE_ONESHOT) && start && !busy_q;
    // An idle one-shot must not advance, so the prescaler is frozen too.
    run      = (mode_sh_q != MODE_ONESHOT) || busy_q;
    ps_en    = en && run;
    ps_clr   = load || start_ok;
    wrap     = step && (cnt_q == '1);

    ld_sh_d    = ld_sh_q;
    cmp_sh_d   = cmp_sh_q;
    presc_sh_d = presc_sh_q;
    mode_sh_d  = mode_sh_q;
    cnt_d      = cnt_q;
    tick_d     = 1'b0;
    wave_d     = wave_q;
    busy_d     = busy_q;

    if (load) begin
      ld_sh_d    = ld_num;
      cmp_sh_d   = cmp;
      presc_sh_d = presc;
      mode_sh_d  = mode_e'(mode);
      cnt_d      = ld_num;
      wave_d     = 1'b0;
      busy_d     = 1'b0;
    end else if (start_ok) begin
      cnt_d  = ld_sh_q;
      busy_d = 1'b1;
      wave_d = 1'b1;
    end else begin
      if (wrap) begin
        ld_sh_d  = ld_num;
        cmp_sh_d = cmp;
        tick_d   = 1'b1;
        if (mode_sh_q == MODE_ONESHOT) begin
          busy_d = 1'b0;
        end else begin
          cnt_d = ld_num;
        end
      end else if (step) begin
        cnt_d = cnt_q + 1'b1;
      end

      // PWM compares against the value cnt will show, keeping wave aligned with cnt.
      unique case (mode_sh_q)
        MODE_PULSE:   wave_d = tick_d;
        MODE_SQUARE:  if (wrap) wave_d = ~wave_q;
        MODE_PWM:     if (en) wave_d = (cnt_d < cmp_sh_d);
        MODE_ONESHOT: wave_d = busy_d;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_sh_q    <= '0;
      cmp_sh_q   <= '0;
      presc_sh_q <= '0;
      mode_sh_q  <= MODE_PULSE;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      wave_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ld_sh_q    <= ld_sh_d;
      cmp_sh_q   <= cmp_sh_d;
      presc_sh_q <= presc_sh_d;
      mode_sh_q  <= mode_sh_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      wave_q     <= wave_d;
      busy_q     <= busy_d;
    end
  end

  assign cnt  = cnt_q;
  assign tick = tick_q;
  assign wave = wave_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_periodic_gen.sv
// Self-checking bench for periodic_gen: directed scenarios plus random stimulus
// compared every cycle against a behavioural model.
module tb_periodic_gen;
  import periodic_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, load, start;
  logic [7:0] ld_num, cmp;
  logic [3:0] presc;
  logic [1:0] mode;
  logic [7:0] cnt;
  logic       tick, wave, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  periodic_gen #(.WIDTH(8), .PRE_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .start(start),
    .ld_num(ld_num), .cmp(cmp), .presc(presc), .mode(mode),
    .cnt(cnt), .tick(tick), .wave(wave), .busy(busy)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: shadowed config, prescale phase, period counter.
  int         m_pre, m_presc, m_cnt, m_ld, m_cmp, m_mode;
  bit         m_tick, m_wave, m_busy, m_valid = 0;

  always @(posedge clk) begin
    bit running, stepped, wrapped;
    if (rst) begin
      m_pre = 0; m_presc = 0; m_cnt = 0; m_ld = 0; m_cmp = 0; m_mode = 0;
      m_tick = 0; m_wave = 0; m_busy = 0; m_valid = 1;
    end else if (load) begin
      m_ld = ld_num; m_cmp = cmp; m_presc = presc; m_mode = mode;
      m_cnt = ld_num; m_pre = 0; m_tick = 0; m_wave = 0; m_busy = 0;
    end else if (m_mode == 3 && start && !m_busy) begin
      m_cnt = m_ld; m_pre = 0; m_busy = 1; m_wave = 1; m_tick = 0;
    end else begin
      running = (m_mode != 3) || m_busy;
      stepped = en && running && (m_pre == m_presc);
      wrapped = stepped && (m_cnt == 255);
      if (en && running) m_pre = stepped ? 0 : m_pre + 1;
      m_tick = wrapped;
      if (wrapped) begin
        m_ld = ld_num; m_cmp = cmp;
        if (m_mode == 3) m_busy = 0;
        else m_cnt = m_ld;
      end else if (stepped) begin
        m_cnt = m_cnt + 1;
      end
      case (m_mode)
        0: m_wave = m_tick;
        1: if (wrapped) m_wave = !m_wave;
        2: if (en) m_wave = (m_cnt < m_cmp);
        default: m_wave = m_busy;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cnt", cnt, m_cnt);
      chk("tick", tick, m_tick);
      chk("wave", wave, m_wave);
      chk("busy", busy, m_busy);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] l, input logic [7:0] c,
                         input logic [3:0] p, input logic [1:0] m);
    ld_num = l; cmp = c; presc = p; mode = m; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_tick(input int maxc, output int n);
    n = 0;
    while (tick !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) chk("tick_timeout", 0, 1);
  endtask

  initial begin
    int n, n2, hi, b, t_seen, prev_wave;
    rst = 1'b1; en = 1'b0; load = 1'b0; start = 1'b0;
    ld_num = '0; cmp = '0; presc = '0; mode = MODE_PULSE;
    cyc(2);
    chk("rst_cnt", cnt, 0); chk("rst_tick", tick, 0);
    chk("rst_wave", wave, 0); chk("rst_busy", busy, 0);
    rst = 1'b0; en = 1'b1;

    // PULSE, 113-cycle period
    do_load(8'd143, 8'd0, 4'd0, MODE_PULSE);
    chk("t1_cnt_after_load", cnt, 143);
    chk("t1_tick_after_load", tick, 0);
    wait_tick(300, n);
    chk("t1_first_tick", n, 113);
    chk("t1_cnt_at_tick", cnt, 143);
    @(negedge clk); chk("t1_tick_width", tick, 0);
    wait_tick(300, n);
    chk("t1_period", n + 1, 113);

    // SQUARE with prescale 4
    do_load(8'd143, 8'd0, 4'd3, MODE_SQUARE);
    for (int k = 0; k < 2; k++) begin
      prev_wave = wave; n = 0;
      while (wave == prev_wave && n < 2000) begin @(negedge clk); n++; end
      chk("t2_half_period", n, 452);
    end
    chk("t2_cnt_at_toggle", cnt, 143);
    cyc(3); chk("t2_cnt_hold", cnt, 143);
    cyc(1); chk("t2_cnt_step", cnt, 144);

    // PWM duty and compare shadowing
    do_load(8'd0, 8'd64, 4'd0, MODE_PWM);
    wait_tick(300, n);
    hi = 0;
    for (int i = 0; i < 256; i++) begin hi += wave; @(negedge clk); end
    chk("t3_duty64", hi, 64);
    chk("t3_tick_p2", tick, 1);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 100) cmp = 8'd192;
      hi += wave; @(negedge clk);
    end
    chk("t3_duty_old_period", hi, 64);
    hi = 0;
    for (int i = 0; i < 256; i++) begin hi += wave; @(negedge clk); end
    chk("t3_duty192", hi, 192);

    // ONESHOT, non-retriggerable, rerun after completion
    do_load(8'd250, 8'd0, 4'd0, MODE_ONESHOT);
    cyc(3);
    chk("t4_idle_busy", busy, 0); chk("t4_idle_cnt", cnt, 250);
    for (int run = 0; run < 2; run++) begin
      start = 1'b1; @(negedge clk); start = 1'b0;
      b = 0; t_seen = 0;
      while (busy === 1'b1 && b < 50) begin
        b++; t_seen += tick;
        start = (b == 2);
        @(negedge clk);
      end
      start = 1'b0;
      chk("t4_busy_len", b, 6);
      chk("t4_tick_end", tick, 1);
      chk("t4_tick_during", t_seen, 0);
      chk("t4_cnt_end", cnt, 255);
      cyc(4);
      chk("t4_cnt_hold", cnt, 255); chk("t4_tick_once", tick, 0);
    end

    // Continuous tick with ld=all-ones
    do_load(8'd255, 8'd0, 4'd0, MODE_PULSE);
    cyc(1);
    t_seen = 0;
    for (int i = 0; i < 5; i++) begin t_seen += tick; @(negedge clk); end
    chk("t_allones_tick", t_seen, 5);

    // Enable freeze and load-on-wrap collision
    do_load(8'd143, 8'd0, 4'd0, MODE_PULSE);
    wait_tick(300, n);
    cyc(20);
    en = 1'b0; cyc(10);
    chk("t5_cnt_frozen", cnt, 163);
    en = 1'b1;
    wait_tick(300, n2);
    chk("t5_period_ext", 30 + n2, 123);
    cyc(112);
    chk("t5_cnt_pre_wrap", cnt, 255);
    ld_num = 8'd100; load = 1'b1; @(negedge clk); load = 1'b0;
    chk("t5_collide_tick", tick, 0);
    chk("t5_collide_cnt", cnt, 100);

    // Reset in the middle of a one-shot
    do_load(8'd200, 8'd0, 4'd0, MODE_ONESHOT);
    start = 1'b1; @(negedge clk); start = 1'b0;
    cyc(3); chk("t6_busy_pre", busy, 1);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("t6_cnt", cnt, 0); chk("t6_busy", busy, 0);
    chk("t6_wave", wave, 0); chk("t6_tick", tick, 0);

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      rst    = ($urandom_range(0, 499) == 0);
      en     = ($urandom_range(0, 9) != 0);
      load   = ($urandom_range(0, 59) == 0);
      start  = ($urandom_range(0, 11) == 0);
      ld_num = 8'($urandom_range(200, 255));
      cmp    = 8'($urandom_range(180, 255));
      presc  = 4'($urandom_range(0, 2));
      mode   = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    rst = 1'b0; load = 1'b0; start = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
